// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed RV32 loads/stores into word-indexed accesses
// on a combinational-read data memory, with read-modify-write for SB/SH.
module load_store_unit #(
   parameter int unsigned WORD_DEPTH = 64,
   parameter int unsigned IDX_W      = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_MemRW,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   if (WORD_DEPTH != (32'd1 << IDX_W)) begin : g_bad_cfg
      $error("load_store_unit: WORD_DEPTH must equal 2**IDX_W");
   end

   logic [1:0]  state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [15:0] wdata_q, wdata_d;

   logic        req_ready_d, resp_valid_d, resp_err_d, mem_MemRW_d;
   logic [31:0] resp_rdata_d, mem_addr_d, mem_wdata_d;

   logic [IDX_W-1:0] req_idx;
   logic [1:0]       req_off;
   logic             f3_legal, misaligned, out_of_range, req_err;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data;
   logic [31:0]      st_word;

   assign req_idx = req_addr[IDX_W+1:2];
   assign req_off = req_addr[1:0];

   // Request legality, evaluated only at accept time
   always_comb begin
      f3_legal = 1'b0;
      if (req_we) begin
         f3_legal = (req_funct3 == F_B) || (req_funct3 == F_H) || (req_funct3 == F_W);
      end else begin
         f3_legal = (req_funct3 == F_B) || (req_funct3 == F_H) || (req_funct3 == F_W) ||
                    (req_funct3 == F_BU) || (req_funct3 == F_HU);
      end
      misaligned   = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
      out_of_range = |req_addr[31:IDX_W+2];
      req_err      = !f3_legal || misaligned || out_of_range;
   end

   // Load extraction and sub-word merge from the word currently read
   always_comb begin
      ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (funct3_q)
         F_B:     ld_data = {{24{ld_byte[7]}}, ld_byte};
         F_H:     ld_data = {{16{ld_half[15]}}, ld_half};
         F_W:     ld_data = mem_rdata;
         F_BU:    ld_data = {24'h000000, ld_byte};
         F_HU:    ld_data = {16'h0000, ld_half};
         default: ld_data = 32'h0000_0000;
      endcase

      st_word = mem_rdata;
      if (funct3_q == F_H) begin
         st_word[{off_q[1], 4'b0000} +: 16] = wdata_q;
      end else begin
         st_word[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      resp_rdata_d = resp_rdata;
      resp_err_d   = resp_err;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d         = req_we;
               funct3_d     = req_funct3;
               off_d        = req_off;
               wdata_d      = req_wdata[15:0];
               resp_rdata_d = 32'h0000_0000;
               resp_err_d   = 1'b0;
               if (req_err) begin
                  state_d    = S_RESP;
                  resp_err_d = 1'b1;
               end else if (!req_we || (req_funct3 != F_W)) begin
                  state_d    = S_RD;
                  mem_addr_d = 32'(req_idx);
               end else begin
                  state_d     = S_WR;
                  mem_addr_d  = 32'(req_idx);
                  mem_wdata_d = req_wdata;
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               state_d     = S_WR;
               mem_wdata_d = st_word;
            end else begin
               state_d      = S_RESP;
               resp_rdata_d = ld_data;
            end
         end
         S_WR: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      req_ready_d  = (state_d == S_IDLE);
      resp_valid_d = (state_d == S_RESP);
      mem_MemRW_d  = (state_d != S_WR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         wdata_q    <= 16'h0000;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
         mem_MemRW  <= 1'b1;
         mem_addr   <= 32'h0000_0000;
         mem_wdata  <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         funct3_q   <= funct3_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_err   <= resp_err_d;
         mem_MemRW  <= mem_MemRW_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: bench-owned word memory, expected responses
// and memory writes queued at drive time and compared when the DUT produces them.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_MemRW;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
   } resp_t;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] data;
   } wr_t;

   resp_t       resp_q[$];
   wr_t         wr_q[$];
   logic [31:0] mem [64];
   logic [31:0] ref_mem [16];
   int          n_vec  = 0;
   int          n_fail = 0;
   int          wr_cnt = 0;

   load_store_unit #(.WORD_DEPTH(64), .IDX_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_MemRW(mem_MemRW), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[5:0]];

   always @(posedge clk) begin
      if (mem_MemRW === 1'b0) mem[mem_addr[5:0]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Every write cycle must match the next queued write
   always @(negedge clk) begin
      wr_t w;
      if (rst_n && mem_MemRW === 1'b0) begin
         wr_cnt++;
         if (wr_q.size() == 0) begin
            check("unexpected_write", 32'(mem_MemRW), 32'd1);
         end else begin
            w = wr_q.pop_front();
            check("wr_addr", mem_addr, 32'(w.idx));
            check("wr_data", mem_wdata, w.data);
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_req_ready",  32'(req_ready),  32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata,      32'd0);
      check("rst_resp_err",   32'(resp_err),   32'd0);
      check("rst_mem_MemRW",  32'(mem_MemRW),  32'd1);
      check("rst_mem_addr",   mem_addr,        32'd0);
      check("rst_mem_wdata",  mem_wdata,       32'd0);
   endtask

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input int hold,
                         input logic exp_wr, input logic [5:0] wr_idx,
                         input logic [31:0] wr_data);
      resp_t r;
      wr_t   w;
      int    lat;
      @(negedge clk);
      check("req_ready", 32'(req_ready), 32'd1);
      r.rdata = exp_rdata;
      r.err   = exp_err;
      r.lat   = 8'(exp_lat);
      resp_q.push_back(r);
      if (exp_wr) begin
         w.idx  = wr_idx;
         w.data = wr_data;
         wr_q.push_back(w);
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      // keep presenting junk while busy; it must be ignored
      req_we     = ~we;
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      @(negedge clk);
      while (!resp_valid && lat < 10) begin
         lat++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      r = resp_q.pop_front();
      check("resp_valid", 32'(resp_valid), 32'd1);
      check("latency", 32'(lat), 32'(r.lat));
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, r.rdata);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      check("resp_rdata", resp_rdata, r.rdata);
      check("resp_err", 32'(resp_err), 32'(r.err));
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   // Reference model for the random phase (words 32..47 only)
   task automatic rnd_op();
      int          w, op, off, sh, lat;
      logic [2:0]  f3;
      logic [31:0] old, nw, mask, v, addr, wdata;
      w     = 32 + $urandom_range(0, 15);
      op    = $urandom_range(0, 7);
      wdata = $urandom;
      case (op)
         0: f3 = 3'b000;
         1: f3 = 3'b001;
         2: f3 = 3'b010;
         3: f3 = 3'b000;
         4: f3 = 3'b001;
         5: f3 = 3'b010;
         6: f3 = 3'b100;
         default: f3 = 3'b101;
      endcase
      case (f3[1:0])
         2'b00:   off = $urandom_range(0, 3);
         2'b01:   off = 2 * $urandom_range(0, 1);
         default: off = 0;
      endcase
      sh   = 8 * off;
      addr = 32'(w * 4 + off);
      old  = ref_mem[w - 32];
      if (op < 3) begin
         if (f3 == 3'b010) begin
            nw  = wdata;
            lat = 2;
         end else begin
            mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
            nw   = (old & ~(mask << sh)) | ((wdata & mask) << sh);
            lat  = 3;
         end
         ref_mem[w - 32] = nw;
         do_req(1'b1, f3, addr, wdata, 32'd0, 1'b0, lat, 0, 1'b1, 6'(w), nw);
      end else begin
         v = old >> sh;
         case (f3)
            3'b000:  v = (v & 32'hFF)   | ((v & 32'h80)   != 0 ? 32'hFFFF_FF00 : 32'h0);
            3'b001:  v = (v & 32'hFFFF) | ((v & 32'h8000) != 0 ? 32'hFFFF_0000 : 32'h0);
            3'b100:  v = v & 32'hFF;
            3'b101:  v = v & 32'hFFFF;
            default: v = old;
         endcase
         do_req(1'b0, f3, addr, wdata, v, 1'b0, 2, $urandom_range(0, 2), 1'b0, 6'd0, 32'd0);
      end
   endtask

   initial begin
      int cnt0;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'd0;
      mem[17]    = 32'h0000_0038;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;

      // Reset during the read phase of an SB abandons it with no write
      @(negedge clk);
      cnt0       = wr_cnt;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h0000_003D;
      req_wdata  = 32'h0000_0055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("rst_ready_after", 32'(req_ready), 32'd1);
      check("rst_no_write", 32'(wr_cnt), 32'(cnt0));
      check("rst_mem15", mem[15], 32'd0);

      // Directed accesses
      do_req(1'b1, 3'b010, 32'h3C, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0, 1'b1, 6'd15, 32'hDEAD_BEEF);
      do_req(1'b0, 3'b010, 32'h3C, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b1, 3'b000, 32'h3D, 32'h0000_0055, 32'd0, 1'b0, 3, 0, 1'b1, 6'd15, 32'hDEAD_55EF);
      do_req(1'b0, 3'b000, 32'h3D, 32'd0, 32'h0000_0055, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b0, 3'b100, 32'h3F, 32'd0, 32'h0000_00DE, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b0, 3'b000, 32'h3F, 32'd0, 32'hFFFF_FFDE, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b1, 3'b001, 32'h46, 32'h1234_ABCD, 32'd0, 1'b0, 3, 0, 1'b1, 6'd17, 32'hABCD_0038);
      do_req(1'b0, 3'b001, 32'h46, 32'd0, 32'hFFFF_ABCD, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);
      // Back-pressure held for 3 cycles, then an immediate follow-on request
      do_req(1'b0, 3'b010, 32'h3C, 32'd0, 32'hDEAD_55EF, 1'b0, 2, 3, 1'b0, 6'd0, 32'd0);
      do_req(1'b0, 3'b101, 32'h46, 32'd0, 32'h0000_ABCD, 1'b0, 2, 0, 1'b0, 6'd0, 32'd0);

      // Errors: no memory write, 1-cycle response
      cnt0 = wr_cnt;
      do_req(1'b0, 3'b010, 32'h41,  32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b0, 3'b001, 32'h43,  32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b1, 3'b010, 32'h100, 32'h1111_2222, 32'd0, 1'b1, 1, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b0, 3'b011, 32'h40,  32'd0, 32'd0, 1'b1, 1, 0, 1'b0, 6'd0, 32'd0);
      do_req(1'b1, 3'b100, 32'h40,  32'h3333_4444, 32'd0, 1'b1, 1, 0, 1'b0, 6'd0, 32'd0);
      check("err_no_write", 32'(wr_cnt), 32'(cnt0));
      check("err_mem16", mem[16], 32'd0);

      for (int i = 0; i < 40; i++) rnd_op();

      repeat (2) @(negedge clk);
      check("pending_writes", 32'(wr_q.size()), 32'd0);
      check("pending_resps", 32'(resp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
